uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Byte buffer between the UART register block (TDR writes) and uart_transmitter.
- Software can queue up to DEPTH bytes without polling SR.txact.
- Pops one byte at a time and launches it with a single-cycle tx_data_valid pulse.
- Tracks the transmitter's busy line so the next byte is launched only after the previous frame completes.

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 2.
- DATA_WIDTH, 8, byte width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  UART enable (CR.en). When 0, no new launch is started.
- flush  input  1  synchronous clear of FIFO contents and overflow flag
- wr_valid  input  1  push strobe (TDR write)
- wr_data  input  DATA_WIDTH  byte to push
- tx_busy  input  1  busy from uart_transmitter
- tx_data_valid  output  1  one-cycle launch pulse to uart_transmitter
- tx_data  output  DATA_WIDTH  byte presented to uart_transmitter; held stable until the frame ends
- empty  output  1  FIFO holds no entries
- full  output  1  FIFO holds DEPTH entries
- level  output  $clog2(DEPTH)+1  number of stored entries
- overflow  output  1  sticky; set when a push arrives while full
- idle  output  1  FIFO empty, FSM in IDLE and tx_busy low (transmission fully drained)

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - pointers 0, level 0, empty 1, full 0, overflow 0
  - tx_data_valid 0, tx_data 0, FSM IDLE, idle 1
- Storage: circular buffer with rd_ptr and wr_ptr of $clog2(DEPTH) bits; both wrap modulo DEPTH. level is a separate counter.
- Push:
  - wr_valid with full=0 writes mem[wr_ptr], increments wr_ptr and level; visible in level the next cycle.
  - wr_valid with full=1 drops the byte, sets overflow, and leaves pointers unchanged.
- Pop: happens only in the IDLE→LAUNCH transition (see FSM). It latches mem[rd_ptr] into tx_data and increments rd_ptr.
- Simultaneous push and pop:
  - level unchanged, both pointers advance.
  - This is allowed even when full=1: the push is accepted because the pop frees a slot in the same cycle.
- FSM states:
  - IDLE: if en && !empty → LAUNCH. The pop occurs on this transition.
  - LAUNCH: tx_data_valid=1 for exactly this cycle → WAIT_START.
  - WAIT_START: wait for tx_busy=1 → WAIT_DONE. The transmitter may raise busy up to one sck period later.
  - WAIT_DONE: wait for tx_busy=0 → IDLE.
- Launch latency: first byte pushed into an empty FIFO with en=1 produces the tx_data_valid pulse 2 cycles after the wr_valid cycle (push at T, pop at T+1, pulse at T+2).
- Back-to-back: after tx_busy falls, the next pulse comes 2 cycles later (IDLE at +1, LAUNCH at +2).
- en=0:
  - A frame already launched runs to completion.
  - The FSM stays in IDLE once it returns there.
  - Pushes are still accepted.
- flush:
  - Resets pointers, level and overflow in the same cycle; overrides a coincident push or pop.
  - It does not abort a frame in WAIT_START/WAIT_DONE; tx_data stays stable.
- Async reset mid-frame: everything returns to reset values immediately. The transmitter's own reset handles the line.
- Outputs empty, full, level and overflow are registered or derived from registered level; no combinational path from wr_valid.

Decomposition:
- uart_pkg gains:
  - UART_TX_FIFO_DEPTH constant
  - uart_tx_fifo_state_t enum (IDLE, LAUNCH, WAIT_START, WAIT_DONE)
  - SR bit positions for txfull, txempty and txovf, for the register block to map.
- One sub-module: sync_fifo. It is generic storage plus pointers, level, full and empty, and is reusable for a future RX FIFO.
- uart_tx_fifo wraps sync_fifo with the launch FSM and the overflow flag.

Test Plan:
- Single byte: en=1, push 0xA5 → tx_data_valid pulse 2 cycles later with tx_data=0xA5. Model busy high for 10 cycles then low → idle=1 at the cycle after busy falls, level=0.
- Burst: push 0x01..0x10 back-to-back (16 bytes) → full=1 then level=15 after the first pop. Launches occur in order 0x01..0x10, each 2 cycles after the previous busy fall. No pulse is issued while busy=1.
- Overflow: en=0, push 17 bytes → level=16, full=1, overflow=1, 17th byte absent from the output sequence. Then flush → level=0, empty=1, overflow=0.
- Push while full with pop: en=0, fill 16, then raise en, and push 0x77 in the same cycle as the pop → accepted, level stays 16, overflow=0. 0x77 is transmitted last.
- Disable mid-stream: 3 bytes queued, drop en during the first frame → first frame completes, no further pulse, level=2. Re-enable → remaining bytes sent in order.
- Reset mid-frame: assert rst_n=0 in WAIT_DONE with level=5 → next cycle level=0, empty=1, tx_data_valid=0, FSM IDLE. No pulse after reset release until a new push.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FIFO sizing, TX FIFO launch-FSM states and
// status-register bit positions used by the register block.
package uart_pkg;

  localparam int unsigned UART_TX_FIFO_DEPTH = 16;

  // Status register (SR) bit positions for the TX FIFO flags
  localparam int unsigned SR_TXEMPTY_BIT = 4;
  localparam int unsigned SR_TXFULL_BIT  = 5;
  localparam int unsigned SR_TXOVF_BIT   = 6;

  typedef enum logic [1:0] {
    TXF_IDLE       = 2'd0,
    TXF_LAUNCH     = 2'd1,
    TXF_WAIT_START = 2'd2,
    TXF_WAIT_DONE  = 2'd3
  } uart_tx_fifo_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO: circular buffer, wrapping pointers, level counter,
// registered full/empty. Reusable for TX and RX paths.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   flush_i           synchronous clear, overrides push/pop
//   push_i, wdata_i   write strobe and data (accepted if not full, or if popping)
//   pop_i             read strobe (ignored when empty)
//   rdata_c_o         head entry, combinational from storage
//   empty_o, full_o   registered flags
//   level_o           registered entry count
//   empty_next_c_o    value empty_o takes after this edge
module sync_fifo #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    pop_i,
  output logic [DATA_WIDTH-1:0]   rdata_c_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    empty_next_c_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  empty_q, full_q;
  logic                  push_ok, pop_ok;

  // A push into a full FIFO is still accepted when a pop frees a slot this cycle
  assign pop_ok  = pop_i && !empty_q && !flush_i;
  assign push_ok = push_i && (!full_q || pop_ok) && !flush_i;

  // Next-state pointers and level
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= (level_d == '0);
      full_q   <= (level_d == LW'(DEPTH));
    end
  end

  // Storage needs no reset; validity is tracked by the level counter
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_c_o      = mem_q[rd_ptr_q];
  assign empty_o        = empty_q;
  assign full_o         = full_q;
  assign level_o        = level_q;
  assign empty_next_c_o = (level_d == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// TX byte buffer between the UART register block and uart_transmitter.
// Queues bytes, pops one at a time and launches it with a one-cycle
// tx_data_valid pulse, then waits for the transmitter's busy to rise and fall.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   en                    UART enable; gates new launches only
//   flush                 clears FIFO contents and overflow
//   wr_valid, wr_data     push strobe and byte (TDR write)
//   tx_busy               busy from uart_transmitter
//   tx_data_valid         one-cycle launch pulse
//   tx_data               byte held stable for the whole frame
//   empty, full, level    FIFO status (registered)
//   overflow              sticky push-while-full flag
//   idle                  FIFO empty, FSM idle, transmitter not busy
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH      = UART_TX_FIFO_DEPTH,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    flush,
  input  logic                    wr_valid,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    tx_busy,
  output logic                    tx_data_valid,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic                    idle
);

  uart_tx_fifo_state_t   state_q;
  logic                  tx_data_valid_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  overflow_q;
  logic                  idle_q;
  logic [DATA_WIDTH-1:0] head_c;
  logic                  empty_next_c;
  logic                  pop_c;
  logic                  to_idle_c;

  sync_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush),
    .push_i         (wr_valid),
    .wdata_i        (wr_data),
    .pop_i          (pop_c),
    .rdata_c_o      (head_c),
    .empty_o        (empty),
    .full_o         (full),
    .level_o        (level),
    .empty_next_c_o (empty_next_c)
  );

  // Pop only on the IDLE->LAUNCH transition; flush suppresses it
  assign pop_c = (state_q == TXF_IDLE) && en && !empty && !flush;

  // FSM will be in IDLE after this edge
  assign to_idle_c = ((state_q == TXF_IDLE) && !pop_c) ||
                     ((state_q == TXF_WAIT_DONE) && !tx_busy);

  // Launch FSM with registered outputs and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= TXF_IDLE;
      tx_data_valid_q <= 1'b0;
      tx_data_q       <= '0;
      overflow_q      <= 1'b0;
      idle_q          <= 1'b1;
    end else begin
      tx_data_valid_q <= 1'b0;
      case (state_q)
        TXF_IDLE: begin
          if (pop_c) begin
            state_q         <= TXF_LAUNCH;
            tx_data_valid_q <= 1'b1;
            tx_data_q       <= head_c;
          end
        end
        TXF_LAUNCH:     state_q <= TXF_WAIT_START;
        TXF_WAIT_START: if (tx_busy)  state_q <= TXF_WAIT_DONE;
        TXF_WAIT_DONE:  if (!tx_busy) state_q <= TXF_IDLE;
        default:        state_q <= TXF_IDLE;
      endcase

      if (flush)                                overflow_q <= 1'b0;
      else if (wr_valid && full && !pop_c)      overflow_q <= 1'b1;

      idle_q <= to_idle_c && empty_next_c && !tx_busy;
    end
  end

  assign tx_data_valid = tx_data_valid_q;
  assign tx_data       = tx_data_q;
  assign overflow      = overflow_q;
  assign idle          = idle_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple transmitter busy model.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH    = 16;
  localparam int unsigned DW       = 8;
  localparam int          BUSY_LEN = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          tx_busy = 1'b0;
  logic          tx_data_valid;
  logic [DW-1:0] tx_data;
  logic          empty, full, overflow, idle;
  logic [4:0]    level;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Transmitter model state
  logic [7:0] launched[$];
  int         pulse_cyc[$];
  int         fall_cyc = 0;
  bit         have_fall = 0;
  bit         chk_b2b = 0;
  bit         pending = 0;
  int         busy_cnt = 0;

  uart_tx_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .wr_valid(wr_valid), .wr_data(wr_data), .tx_busy(tx_busy),
    .tx_data_valid(tx_data_valid), .tx_data(tx_data),
    .empty(empty), .full(full), .level(level),
    .overflow(overflow), .idle(idle)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Transmitter model: busy rises the cycle after a launch, stays high BUSY_LEN cycles
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      tx_busy  = 1'b0;
      busy_cnt = 0;
      pending  = 0;
    end else begin
      if (tx_data_valid) begin
        check("no_pulse_while_busy", {31'd0, tx_busy || pending || busy_cnt != 0}, 32'd0);
        if (chk_b2b && have_fall) check("b2b_latency", cyc - fall_cyc, 32'd2);
        have_fall = 0;
        launched.push_back(tx_data);
        pulse_cyc.push_back(cyc);
        pending = 1;
      end else if (pending) begin
        tx_busy  = 1'b1;
        busy_cnt = BUSY_LEN;
        pending  = 0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          tx_busy   = 1'b0;
          fall_cyc  = cyc;
          have_fall = 1;
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_launches(input string tag, input int n);
    for (int i = 0; i < 2000 && launched.size() < n; i++) @(negedge clk);
    check(tag, launched.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && idle !== 1'b1; i++) @(negedge clk);
    check(tag, {31'd0, idle}, 32'd1);
  endtask

  initial begin
    int base;
    int t0;

    // Reset values
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_valid", tx_data_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_idle", idle, 1);

    // Single byte: pulse two cycles after push, idle the cycle after busy falls
    en = 1'b1;
    t0 = cyc;
    push_byte(8'hA5);
    wait_launches("single_launch", 1);
    check("single_latency", pulse_cyc[0] - t0, 2);
    check("single_data", launched[0], 8'hA5);
    wait_idle("single_idle");
    check("single_idle_time", cyc - fall_cyc, 1);
    check("single_level", level, 0);
    check("single_tx_data_held", tx_data, 8'hA5);

    // Burst of 16 with en low, then launch in order back-to-back
    en = 1'b0;
    base = launched.size();
    for (int i = 1; i <= 16; i++) push_byte(8'(i));
    check("burst_full", full, 1);
    check("burst_level16", level, 16);
    en = 1'b1;
    @(negedge clk);
    check("burst_level15", level, 15);
    wait_launches("burst_first", base + 1);
    chk_b2b = 1;
    wait_launches("burst_all", base + 16);
    wait_idle("burst_idle");
    chk_b2b = 0;
    for (int i = 0; i < 16; i++) check("burst_order", launched[base+i], 32'(i + 1));

    // Overflow: 17th byte dropped and sticky flag set
    en = 1'b0;
    base = launched.size();
    for (int i = 0; i < 17; i++) push_byte(8'h20 + 8'(i));
    check("ovf_level", level, 16);
    check("ovf_full", full, 1);
    check("ovf_flag", overflow, 1);
    en = 1'b1;
    wait_launches("ovf_drain", base + 16);
    wait_idle("ovf_idle");
    check("ovf_count", launched.size(), base + 16);
    check("ovf_last", launched[base+15], 8'h2F);
    check("ovf_sticky", overflow, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_level", level, 0);
    check("flush_empty", empty, 1);
    check("flush_overflow", overflow, 0);

    // Push while full, coincident with the pop
    en = 1'b0;
    base = launched.size();
    for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i));
    en       = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    @(negedge clk);
    wr_valid = 1'b0;
    check("fullpop_level", level, 16);
    check("fullpop_overflow", overflow, 0);
    wait_launches("fullpop_drain", base + 17);
    wait_idle("fullpop_idle");
    for (int i = 0; i < 16; i++) check("fullpop_order", launched[base+i], 32'h40 + 32'(i));
    check("fullpop_last", launched[base+16], 8'h77);

    // Disable mid-stream: current frame completes, nothing more launched
    base = launched.size();
    push_byte(8'h91);
    push_byte(8'h92);
    push_byte(8'h93);
    wait_launches("dis_first", base + 1);
    en = 1'b0;
    repeat (30) @(negedge clk);
    check("dis_count", launched.size(), base + 1);
    check("dis_level", level, 2);
    check("dis_busy_low", tx_busy, 0);
    en = 1'b1;
    wait_launches("dis_resume", base + 3);
    check("dis_b0", launched[base], 8'h91);
    check("dis_b1", launched[base+1], 8'h92);
    check("dis_b2", launched[base+2], 8'h93);
    wait_idle("dis_idle");

    // Reset in WAIT_DONE with five bytes left
    en = 1'b0;
    base = launched.size();
    for (int i = 0; i < 6; i++) push_byte(8'hB0 + 8'(i));
    en = 1'b1;
    wait_launches("rstm_launch", base + 1);
    en = 1'b0;
    for (int i = 0; i < 50 && tx_busy !== 1'b1; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("rstm_pre_level", level, 5);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstm_level", level, 0);
    check("rstm_empty", empty, 1);
    check("rstm_valid", tx_data_valid, 0);
    check("rstm_tx_data", tx_data, 0);
    check("rstm_idle", idle, 1);
    rst_n = 1'b1;
    en = 1'b1;
    repeat (20) @(negedge clk);
    check("rstm_no_launch", launched.size(), base + 1);
    push_byte(8'hC3);
    wait_launches("rstm_new", base + 2);
    check("rstm_new_data", launched[base+1], 8'hC3);
    wait_idle("rstm_idle_end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
